pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0040: PC loaded on exception.
REQ-002 Parameter WDOG_LIMIT, default 8'd255: count of consecutive stalled cycles that raises stall_timeout.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high (1 = RstEnable).
REQ-005 stallreq_id  input  1  ID stage requests a stall.
REQ-006 stallreq_ex  input  1  EX stage requests a stall.
REQ-007 stallreq_mem  input  1  MEM stage requests a stall.
REQ-008 branch_flag_i  input  1  taken branch/jump resolved this cycle.
REQ-009 branch_target_i  input  32  target PC of that branch.
REQ-010 excp_flag_i  input  1  exception raised this cycle.
REQ-011 stall  output  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold (StallEnable).
REQ-012 pc_we  output  1  1-cycle pulse: PC register loads pc_write_instr.
REQ-013 pc_write_instr  output  32  redirect PC, valid when pc_we=1.
REQ-014 flush  output  1  1-cycle pulse: clear IF/ID/EX/MEM pipeline registers.
REQ-015 stall_timeout  output  1  sticky watchdog error flag.

Function
REQ-016 stall SHALL be combinational from current requests and state; pc_we, pc_write_instr, flush, stall_timeout SHALL be registered.
REQ-017 In state RUN, stall SHALL be: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000 (priority MEM > EX > ID).
REQ-018 FSM states SHALL be RUN and FLUSH only; reset state RUN.
REQ-019 RUN with excp_flag_i=1: next cycle state=FLUSH, flush=1, pc_we=1, pc_write_instr=EXC_VECTOR; any pending branch SHALL be discarded.
REQ-020 FLUSH SHALL last exactly one cycle: stall=6'b000000 regardless of requests, excp_flag_i and branch_flag_i ignored; next state RUN.
REQ-021 RUN, excp_flag_i=0, branch_flag_i=1, stall=0: next cycle pc_we=1, pc_write_instr=branch_target_i (1-cycle latency).
REQ-022 RUN, excp_flag_i=0, branch_flag_i=1, stall!=0: target SHALL be latched into a pending register (valid bit set); no pc_we.
REQ-023 A new branch while pending valid SHALL overwrite the pending target.
REQ-024 Pending valid and stall=0 and no excp/branch this cycle: next cycle pc_we=1 with pending target; pending cleared.
REQ-025 Pending valid, stall=0, new branch this cycle: new branch_target_i SHALL be issued; pending cleared.
REQ-026 Simultaneous excp_flag_i and branch_flag_i: exception wins, branch dropped.
REQ-027 pc_we and flush SHALL be 0 in every cycle not named above; pc_write_instr holds last value when pc_we=0.
REQ-028 Watchdog: 8-bit counter increments each cycle stall!=0, clears to 0 when stall=0, saturates at 8'hFF.
REQ-029 stall_timeout SHALL set the cycle after counter reaches WDOG_LIMIT and remain 1 until reset.

Reset
REQ-030 rst=1 at posedge: state=RUN, pc_we=0, pc_write_instr=32'h0, flush=0, pending cleared, counter=0, stall_timeout=0.
REQ-031 While rst=1, stall SHALL be 6'b000000; reset mid-FLUSH or mid-pending SHALL abort with no pc_we after release.

Verification
REQ-032 stallreq_id=1 and stallreq_mem=1 same cycle -> stall=6'b011111; drop mem -> 6'b000111.
REQ-033 branch_flag_i=1, target 32'h0000_1000, no stalls -> next cycle pc_we=1, pc_write_instr=32'h0000_1000, following cycle pc_we=0.
REQ-034 stallreq_ex=1 for 3 cycles with branch to 32'h2000 in cycle 1 and 32'h3000 in cycle 2 -> no pc_we while stalled; one pc_we with 32'h3000 the cycle after stall drops.
REQ-035 excp_flag_i=1 with branch_flag_i=1 and stallreq_mem=1 -> next cycle flush=1, pc_we=1, pc_write_instr=32'h0000_0040, stall=0; branch never issued.
REQ-036 stallreq_id held 300 cycles, WDOG_LIMIT=255 -> stall_timeout=1 after cycle 256, stays 1 after stall drops until rst.
REQ-037 Pending branch latched, rst pulsed 1 cycle -> all outputs reset values, no pc_we after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, branch/exception PC redirect,
// one-cycle flush sequencing and a stall watchdog.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [7:0]  WDOG_LIMIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        excp_flag_i,
  output logic [5:0]  stall,
  output logic        pc_we,
  output logic [31:0] pc_write_instr,
  output logic        flush,
  output logic        stall_timeout
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  state_t      state_nx;
  logic        pend_v;
  logic        pend_v_nx;
  logic [31:0] pend_t;
  logic [31:0] pend_t_nx;
  logic        pc_we_nx;
  logic        flush_nx;
  logic [31:0] pcw_nx;
  logic [7:0]  wdog;
  logic        stalled;

  // Stall vector: deepest requesting stage wins; nothing held in FLUSH
  always_comb begin
    stall = 6'b000000;
    if (!rst && state == RUN) begin
      if (stallreq_mem)
        stall = 6'b011111;
      else if (stallreq_ex)
        stall = 6'b001111;
      else if (stallreq_id)
        stall = 6'b000111;
    end
  end

  assign stalled = |stall;

  // Next state, redirect and pending-branch bookkeeping
  always_comb begin
    state_nx  = state;
    pc_we_nx  = 1'b0;
    flush_nx  = 1'b0;
    pcw_nx    = pc_write_instr;
    pend_v_nx = pend_v;
    pend_t_nx = pend_t;
    case (state)
      RUN: begin
        if (excp_flag_i) begin
          state_nx  = FLUSH;
          flush_nx  = 1'b1;
          pc_we_nx  = 1'b1;
          pcw_nx    = EXC_VECTOR;
          pend_v_nx = 1'b0;
        end else if (branch_flag_i) begin
          if (!stalled) begin
            pc_we_nx  = 1'b1;
            pcw_nx    = branch_target_i;
            pend_v_nx = 1'b0;
          end else begin
            pend_v_nx = 1'b1;
            pend_t_nx = branch_target_i;
          end
        end else if (pend_v && !stalled) begin
          pc_we_nx  = 1'b1;
          pcw_nx    = pend_t;
          pend_v_nx = 1'b0;
        end
      end
      FLUSH: state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc_we          <= 1'b0;
      flush          <= 1'b0;
      pc_write_instr <= 32'h0;
      pend_v         <= 1'b0;
      pend_t         <= 32'h0;
    end else begin
      state          <= state_nx;
      pc_we          <= pc_we_nx;
      flush          <= flush_nx;
      pc_write_instr <= pcw_nx;
      pend_v         <= pend_v_nx;
      pend_t         <= pend_t_nx;
    end
  end

  // Watchdog: count consecutive stalled cycles, sticky timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog          <= 8'h00;
      stall_timeout <= 1'b0;
    end else begin
      if (!stalled)
        wdog <= 8'h00;
      else if (wdog != 8'hFF)
        wdog <= wdog + 8'h01;
      if (wdog >= WDOG_LIMIT)
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model predictions,
// a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam logic [31:0] EXC = 32'h0000_0040;
  localparam int          LIM = 255;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        excp_flag_i;
  logic [5:0]  stall;
  logic        pc_we;
  logic [31:0] pc_write_instr;
  logic        flush;
  logic        stall_timeout;

  pipe_ctrl #(.EXC_VECTOR(EXC), .WDOG_LIMIT(8'd255)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i),
    .excp_flag_i(excp_flag_i),
    .stall(stall),
    .pc_we(pc_we),
    .pc_write_instr(pc_write_instr),
    .flush(flush),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        pc_we;
    logic [31:0] pcw;
    logic        flush;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_flushing;
  logic [31:0] m_pend[$];
  int          m_run;
  logic        m_pc_we;
  logic [31:0] m_pcw;
  logic        m_flush;
  logic        m_tmo;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flushing = 0;
    m_pend.delete();
    m_run   = 0;
    m_pc_we = 0;
    m_pcw   = 32'h0;
    m_flush = 0;
    m_tmo   = 0;
  endtask

  // one clock cycle: drive, predict, advance model across the edge
  task automatic cyc(input bit r, input bit i, input bit e, input bit m,
                     input bit b, input logic [31:0] t, input bit x);
    int   n;
    logic [5:0] s;
    exp_t ex;
    rst = r; stallreq_id = i; stallreq_ex = e; stallreq_mem = m;
    branch_flag_i = b; branch_target_i = t; excp_flag_i = x;
    n = m ? 5 : e ? 4 : i ? 3 : 0;
    if (r || m_flushing) n = 0;
    s = 6'((1 << n) - 1);
    ex.stall = s; ex.pc_we = m_pc_we; ex.pcw = m_pcw;
    ex.flush = m_flush; ex.tmo = m_tmo;
    q.push_back(ex);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      m_pc_we = 0;
      m_flush = 0;
      if (m_run >= LIM) m_tmo = 1;
      m_run = (s != 0) ? m_run + 1 : 0;
      if (m_flushing) begin
        m_flushing = 0;
      end else if (x) begin
        m_flushing = 1;
        m_flush = 1;
        m_pc_we = 1;
        m_pcw = EXC;
        m_pend.delete();
      end else if (b) begin
        m_pend.delete();
        if (s == 0) begin
          m_pc_we = 1;
          m_pcw = t;
        end else begin
          m_pend.push_back(t);
        end
      end else if (m_pend.size() > 0 && s == 0) begin
        m_pc_we = 1;
        m_pcw = m_pend.pop_front();
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  // monitor: compare DUT against each prediction mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("pc_we", 32'(pc_we), 32'(e.pc_we));
        chk("pc_write_instr", pc_write_instr, e.pcw);
        chk("flush", 32'(flush), 32'(e.flush));
        chk("stall_timeout", 32'(stall_timeout), 32'(e.tmo));
      end
    end
  end

  initial begin
    rst = 1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    branch_flag_i = 0; branch_target_i = 0; excp_flag_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    idle();
    // id+mem together, then drop mem
    cyc(0, 1, 0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 1, 0, 0, 32'h0, 0);
    idle();
    // unstalled branch
    cyc(0, 0, 0, 0, 1, 32'h0000_1000, 0);
    idle(); idle();
    // pending branch overwritten while stalled
    cyc(0, 0, 1, 0, 1, 32'h0000_2000, 0);
    cyc(0, 0, 1, 0, 1, 32'h0000_3000, 0);
    cyc(0, 0, 1, 0, 0, 32'h0, 0);
    idle(); idle(); idle();
    // exception beats branch and stall; flush cycle ignores inputs
    cyc(0, 0, 0, 1, 1, 32'h0000_5000, 1);
    cyc(0, 0, 0, 1, 1, 32'h0000_6000, 1);
    idle(); idle();
    // exception discards a pending branch
    cyc(0, 1, 0, 0, 1, 32'h0000_8000, 0);
    cyc(0, 0, 0, 0, 0, 32'h0, 1);
    idle(); idle(); idle();
    // watchdog
    repeat (300) cyc(0, 1, 0, 0, 0, 32'h0, 0);
    repeat (5) idle();
    cyc(1, 0, 0, 0, 0, 32'h0, 0);
    idle();
    // reset while a branch is pending
    cyc(0, 0, 1, 0, 1, 32'h0000_7000, 0);
    cyc(1, 0, 1, 0, 0, 32'h0, 0);
    idle(); idle(); idle();
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      cyc($urandom_range(99) < 2,
          $urandom_range(3) == 0,
          $urandom_range(4) == 0,
          $urandom_range(5) == 0,
          $urandom_range(2) == 0,
          {$urandom_range(32'hFFFF), 2'b00},
          $urandom_range(99) < 8);
    end
    idle(); idle();
    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
